// File: rtl/rle_decode_sequencer_pkg.sv
// Shared constants and FSM state type for the run-length decode sequencer.
package rle_pkg;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_FLUSH
    } rle_seq_state_t;
endpackage

// File: rtl/rle_decode_sequencer_if.sv
// Coded-pair input, flush handshake and decoded-word output of the sequencer.
interface rle_decode_sequencer_if #(
    parameter int STAT_W = 32
);
    import rle_pkg::*;

    logic                pair_valid;
    logic                pair_ready;
    logic [BYTE_W-1:0]   pair_char;
    logic [BYTE_W-1:0]   pair_count;
    logic                flush;
    logic                flush_done;
    logic                word_valid;
    logic                word_ready;
    logic [WORD_W-1:0]   word_data;
    logic                word_last;
    logic [STAT_W-1:0]   stat_bytes;

    modport master (
        output pair_valid, pair_char, pair_count, flush, word_ready,
        input  pair_ready, flush_done, word_valid, word_data, word_last, stat_bytes
    );

    modport slave (
        input  pair_valid, pair_char, pair_count, flush, word_ready,
        output pair_ready, flush_done, word_valid, word_data, word_last, stat_bytes
    );
endinterface

// File: rtl/rle_decode_sequencer_packer.sv
// rle_word_packer: gathers bytes MSB-first into 32-bit words and holds the output
// register until the sink accepts it.
module rle_word_packer
    import rle_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAD_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic              pad_en,
    input  logic              word_ready,
    output logic [IDX_W-1:0]  idx,
    output logic              slot_free,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last
);
    logic [BYTE_W-1:0] acc_q [WORD_BYTES-1];
    logic [BYTE_W-1:0] acc_d [WORD_BYTES-1];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              word_valid_q, word_valid_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_last_q, word_last_d;

    // Accept and reload may share one edge, which keeps one byte per clock flowing.
    assign slot_free  = !word_valid_q || word_ready;
    assign idx        = idx_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_last  = word_last_q;

    always_comb begin
        acc_d        = acc_q;
        idx_d        = idx_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_last_d  = word_last_q;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (wr_en) begin
            if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
                word_data_d  = {acc_q[0], acc_q[1], acc_q[2], wr_byte};
                word_last_d  = 1'b0;
                word_valid_d = 1'b1;
                idx_d        = '0;
            end else begin
                case (idx_q)
                    2'd0:    acc_d[0] = wr_byte;
                    2'd1:    acc_d[1] = wr_byte;
                    default: acc_d[2] = wr_byte;
                endcase
                idx_d = idx_q + 1'b1;
            end
        end else if (pad_en) begin
            // Slot 0 is always filled here; slots at or beyond idx become padding.
            word_data_d  = {acc_q[0],
                            (idx_q > 2'd1) ? acc_q[1] : PAD_CHAR,
                            (idx_q > 2'd2) ? acc_q[2] : PAD_CHAR,
                            PAD_CHAR};
            word_last_d  = 1'b1;
            word_valid_d = 1'b1;
            idx_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q        <= '{default: '0};
            idx_q        <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_last_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_last_q  <= word_last_d;
        end
    end
endmodule

// File: rtl/rle_decode_sequencer.sv
// Run-length decode sequencer: expands (char, count) pairs into packed 32-bit words.
// Optional byte statistics counter enabled by defining RLE_SEQ_STATS_EN.
module rle_decode_sequencer
    import rle_pkg::*;
#(
    parameter logic [BYTE_W-1:0] PAD_CHAR = 8'h00,
    parameter int                STAT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rle_decode_sequencer_if.slave bus
);
    rle_seq_state_t    state_q, state_d;
    logic [BYTE_W-1:0] char_q, char_d;
    logic [BYTE_W-1:0] remain_q, remain_d;
    logic              flush_done_q, flush_done_d;

    logic              wr_en;
    logic              pad_en;
    logic              flush_req;
    logic [IDX_W-1:0]  idx;
    logic              slot_free;

    // A flush still held during its own done pulse must not start a second flush.
    assign flush_req      = bus.flush && !flush_done_q;
    assign bus.pair_ready = reset_n && (state_q == S_IDLE) && !bus.flush;
    assign bus.flush_done = flush_done_q;

    always_comb begin
        state_d      = state_q;
        char_d       = char_q;
        remain_d     = remain_q;
        flush_done_d = 1'b0;
        wr_en        = 1'b0;
        pad_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (bus.pair_valid && !bus.flush) begin
                    if (bus.pair_count != '0) begin
                        char_d   = bus.pair_char;
                        remain_d = bus.pair_count;
                        state_d  = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                if ((idx != IDX_W'(WORD_BYTES - 1)) || slot_free) begin
                    wr_en    = 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == 8'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (idx == '0) begin
                    flush_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (slot_free) begin
                    pad_en       = 1'b1;
                    flush_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            char_q       <= '0;
            remain_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            char_q       <= char_d;
            remain_q     <= remain_d;
            flush_done_q <= flush_done_d;
        end
    end

    rle_word_packer #(
        .PAD_CHAR (PAD_CHAR)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_byte    (char_q),
        .pad_en     (pad_en),
        .word_ready (bus.word_ready),
        .idx        (idx),
        .slot_free  (slot_free),
        .word_valid (bus.word_valid),
        .word_data  (bus.word_data),
        .word_last  (bus.word_last)
    );

`ifdef RLE_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [2:0]        stat_add;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [2:0]        b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {{(STAT_W - 2){1'b0}}, b};
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

    // Padding bytes are excluded: a flushed word contributes only its idx real bytes.
    always_comb begin
        stat_add = 3'd0;
        if (wr_en && (idx == IDX_W'(WORD_BYTES - 1))) begin
            stat_add = 3'(WORD_BYTES);
        end else if (pad_en) begin
            stat_add = {1'b0, idx};
        end
        stat_d = sat_add(stat_q, stat_add);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.stat_bytes = stat_q;
`else
    assign bus.stat_bytes = '0;
`endif
endmodule

// File: tb/tb_rle_decode_sequencer.sv
// Self-checking bench for rle_decode_sequencer: directed table, corner sequences, random traffic.
module tb_rle_decode_sequencer;
    import rle_pkg::*;

    localparam logic [7:0] PAD    = 8'h30;
    localparam int         STAT_W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rle_decode_sequencer_if #(.STAT_W(STAT_W)) bus ();

    rle_decode_sequencer #(
        .PAD_CHAR (PAD),
        .STAT_W   (STAT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic fixed_rdy = 1'b1;
    logic rand_rdy  = 1'b0;
    logic rnd_bit   = 1'b1;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);
    assign bus.word_ready = rand_rdy ? rnd_bit : fixed_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte stream chopped into 4-byte words, flush pads the tail.
    logic [7:0]  pend [$];
    logic [32:0] expq [$];
    int          model_stat = 0;

    task automatic model_emit(input logic last);
        logic [31:0] w;
        w = {pend[0], pend[1], pend[2], pend[3]};
        for (int i = 0; i < 4; i++) void'(pend.pop_front());
        expq.push_back({last, w});
    endtask

    task automatic model_pair(input logic [7:0] c, input logic [7:0] n);
        for (int i = 0; i < int'(n); i++) begin
            pend.push_back(c);
            if (pend.size() == 4) begin
                model_emit(1'b0);
                model_stat += 4;
            end
        end
    endtask

    task automatic model_flush();
        if (pend.size() > 0) begin
            model_stat += pend.size();
            while (pend.size() < 4) pend.push_back(PAD);
            model_emit(1'b1);
        end
    endtask

    // Output monitor: scoreboard compare on each handshake, and hold check while stalled.
    int          words_seen = 0;
    logic [31:0] last_data  = '0;
    logic        last_flag  = 1'b0;
    logic        hold_pend  = 1'b0;
    logic [32:0] hold_val   = '0;

    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else if (bus.word_valid) begin
            if (hold_pend) chk("hold_stable", {31'b0, bus.word_last, bus.word_data}, {31'b0, hold_val});
            if (bus.word_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h last=%0b, expected no word", bus.word_data, bus.word_last);
                end else begin
                    chk("word", {31'b0, bus.word_last, bus.word_data}, {31'b0, expq.pop_front()});
                end
                words_seen++;
                last_data = bus.word_data;
                last_flag = bus.word_last;
                hold_pend = 1'b0;
            end else begin
                hold_pend = 1'b1;
                hold_val  = {bus.word_last, bus.word_data};
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic send_pair(input logic [7:0] c, input logic [7:0] n);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        @(negedge clk);
        bus.pair_valid = 1'b1;
        bus.pair_char  = c;
        bus.pair_count = n;
        while (!acc && t < 2000) begin
            #1;
            if (bus.pair_ready) acc = 1'b1;
            @(negedge clk);
            t++;
        end
        bus.pair_valid = 1'b0;
        if (acc) model_pair(c, n);
        else chk("pair_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic do_flush();
        int   t;
        logic got;
        t   = 0;
        got = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        model_flush();
        while (!got && t < 2000) begin
            @(negedge clk);
            t++;
            if (bus.flush_done) got = 1'b1;
        end
        bus.flush = 1'b0;
        chk("flush_done_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("flush_done_single", 64'(bus.flush_done), 64'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || bus.word_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(expq.size()), 64'd0);
    endtask

    task automatic check_stat(input string name);
`ifdef RLE_SEQ_STATS_EN
        chk(name, 64'(bus.stat_bytes), 64'(model_stat));
`else
        chk(name, 64'(bus.stat_bytes), 64'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pair_ready"}, 64'(bus.pair_ready), 64'd0);
        chk({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
        chk({tag, "_word_data"},  64'(bus.word_data),  64'd0);
        chk({tag, "_word_last"},  64'(bus.word_last),  64'd0);
        chk({tag, "_flush_done"}, 64'(bus.flush_done), 64'd0);
        chk({tag, "_stat"},       64'(bus.stat_bytes), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  n;
        int          nw;
        logic [31:0] lastw;
        logic        lastf;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int w0;
        logic [7:0] rc, rn;

        tbl[0] = '{8'h41, 8'd4,  1, 32'h41414141, 1'b0};
        tbl[1] = '{8'h41, 8'd7,  2, 32'h41414130, 1'b1};
        tbl[2] = '{8'h42, 8'd1,  1, 32'h42303030, 1'b1};
        tbl[3] = '{8'h43, 8'd0,  0, 32'h00000000, 1'b0};
        tbl[4] = '{8'h44, 8'd9,  3, 32'h44303030, 1'b1};
        tbl[5] = '{8'h45, 8'd8,  2, 32'h45454545, 1'b0};

        bus.pair_valid = 1'b0;
        bus.pair_char  = '0;
        bus.pair_count = '0;
        bus.flush      = 1'b0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Latency: pair accepted at edge N, word visible after edge N+4.
        send_pair(8'h41, 8'd4);
        chk("expand_pair_ready", 64'(bus.pair_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("lat_valid_early", 64'(bus.word_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(bus.word_valid), 64'd1);
        chk("lat_data",  64'(bus.word_data),  64'h41414141);
        chk("lat_last",  64'(bus.word_last),  64'd0);
        chk("idle_pair_ready", 64'(bus.pair_ready), 64'd1);
        drain();

        for (int i = 0; i < 6; i++) begin
            w0 = words_seen;
            send_pair(tbl[i].c, tbl[i].n);
            do_flush();
            drain();
            chk($sformatf("tbl%0d_nwords", i), 64'(words_seen - w0), 64'(tbl[i].nw));
            if (tbl[i].nw > 0) begin
                chk($sformatf("tbl%0d_lastw", i), 64'(last_data), 64'(tbl[i].lastw));
                chk($sformatf("tbl%0d_lastf", i), 64'(last_flag), 64'(tbl[i].lastf));
            end
        end
        check_stat("stat_after_table");

        // Run crossing a word boundary, second pair completes the word exactly.
        w0 = words_seen;
        send_pair(8'h41, 8'd7);
        send_pair(8'h37, 8'd1);
        do_flush();
        drain();
        chk("span_nwords", 64'(words_seen - w0), 64'd2);
        chk("span_lastw",  64'(last_data), 64'h41414137);
        chk("span_lastf",  64'(last_flag), 64'd0);

        // Sink stalls for 10 cycles mid-run; output must hold and no byte may be lost.
        w0 = words_seen;
        fixed_rdy = 1'b0;
        send_pair(8'h42, 8'd12);
        repeat (10) @(negedge clk);
        chk("stall_valid", 64'(bus.word_valid), 64'd1);
        chk("stall_data",  64'(bus.word_data),  64'h42424242);
        fixed_rdy = 1'b1;
        do_flush();
        drain();
        chk("stall_nwords", 64'(words_seen - w0), 64'd3);

        // Reset in the middle of a long run drops everything.
        send_pair(8'h43, 8'd200);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        expq.delete();
        pend.delete();
        model_stat = 0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        reset_n = 1'b1;
        w0 = words_seen;
        send_pair(8'h51, 8'd6);
        do_flush();
        drain();
        chk("post_reset_nwords", 64'(words_seen - w0), 64'd2);
        chk("post_reset_lastw",  64'(last_data), 64'h51513030);
        check_stat("post_reset_stat");

        // Random traffic with random sink backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rc = 8'($urandom_range(0, 255));
            rn = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 14));
            send_pair(rc, rn);
            if ($urandom_range(0, 4) == 0) do_flush();
        end
        do_flush();
        rand_rdy = 1'b0;
        drain();
        check_stat("random_stat");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
